// File: rtl/perturbation_irq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perturbation_irq_gen: bench irq source (pass-through, random, PC-trigger) |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module perturbation_irq_gen #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter int unsigned GAP_W     = 8,
  parameter int unsigned MIN_GAP   = 4,
  parameter int unsigned HOLD_MAX  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] mode_i,
  input  logic [31:0] irq_std_i,
  input  logic [31:0] irq_mask_i,
  input  logic [4:0]  irq_id_cfg_i,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_trig_i,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_ack_id_i,
  input  logic        seed_load_i,
  input  logic [31:0] seed_i,
  output logic [31:0] irq_o,
  output logic        irq_pending_o,
  output logic [31:0] irq_count_o
);

  localparam logic [31:0]  C_LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0]  C_MODE_STD  = 32'd1;
  localparam logic [31:0]  C_MODE_RND  = 32'd2;
  localparam logic [31:0]  C_MODE_PC   = 32'd3;
  localparam logic [GAP_W:0] C_MIN_GAP = (GAP_W+1)'(MIN_GAP);
  localparam logic [31:0]  C_HOLD_MAX  = HOLD_MAX;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

  state_t         r_state,    w_state_nxt;
  logic [31:0]    r_lfsr,     w_lfsr_nxt;
  logic [GAP_W:0] r_gap_cnt,  w_gap_cnt_nxt;
  logic [4:0]     r_id,       w_id_nxt;
  logic [31:0]    r_hold_cnt, w_hold_cnt_nxt;
  logic           r_pc_armed, w_pc_armed_nxt;
  logic [31:0]    r_irq,      w_irq_nxt;
  logic [31:0]    r_count,    w_count_nxt;
  logic [31:0]    r_mode_q;

  logic [GAP_W:0] w_gap_load;
  logic [4:0]     w_cand_id;
  logic           w_mode_chg;
  logic           w_pc_hit;
  logic           w_ack_hit;
  logic           w_timeout;

  assign w_gap_load = {1'b0, r_lfsr[GAP_W-1:0]} + C_MIN_GAP;
  assign w_cand_id  = r_lfsr[31:27];
  assign w_mode_chg = (mode_i != r_mode_q);
  assign w_pc_hit   = pc_valid_i && (pc_i == pc_trig_i) && r_pc_armed;
  assign w_ack_hit  = irq_ack_i && (irq_ack_id_i == r_id);
  assign w_timeout  = (C_HOLD_MAX != 32'd0) && (r_hold_cnt == C_HOLD_MAX);

  // LFSR free-runs in every mode; a zero seed would lock it up, so fall back
  always_comb begin
    if (seed_load_i) begin
      w_lfsr_nxt = (seed_i == 32'd0) ? LFSR_SEED : seed_i;
    end else begin
      w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? C_LFSR_MASK : 32'd0);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_id_nxt       = r_id;
    w_hold_cnt_nxt = r_hold_cnt;
    w_irq_nxt      = r_irq;
    w_count_nxt    = r_count;
    w_pc_armed_nxt = r_pc_armed;

    // Re-arm only after the core has moved off the target (e.g. past mret)
    if (pc_valid_i && (pc_i != pc_trig_i)) begin
      w_pc_armed_nxt = 1'b1;
    end

    if (w_mode_chg) begin
      w_state_nxt    = ST_IDLE;
      w_irq_nxt      = 32'd0;
      w_pc_armed_nxt = 1'b1;
    end else begin
      case (mode_i)
        C_MODE_STD: begin
          w_state_nxt = ST_IDLE;
          w_irq_nxt   = irq_std_i;
        end
        C_MODE_RND, C_MODE_PC: begin
          case (r_state)
            ST_IDLE: begin
              w_irq_nxt = 32'd0;
              if (mode_i == C_MODE_RND) begin
                w_gap_cnt_nxt = w_gap_load;
                w_state_nxt   = ST_GAP;
              end else if (w_pc_hit) begin
                w_id_nxt       = irq_id_cfg_i;
                w_pc_armed_nxt = 1'b0;
                w_hold_cnt_nxt = 32'd1;
                w_irq_nxt      = 32'd1 << irq_id_cfg_i;
                w_state_nxt    = ST_ASSERT;
              end
            end
            ST_GAP: begin
              if (r_gap_cnt != '0) begin
                w_gap_cnt_nxt = r_gap_cnt - 1'b1;
              end else if (irq_mask_i[w_cand_id]) begin
                w_id_nxt       = w_cand_id;
                w_hold_cnt_nxt = 32'd1;
                w_irq_nxt      = 32'd1 << w_cand_id;
                w_state_nxt    = ST_ASSERT;
              end
            end
            ST_ASSERT: begin
              // hold_cnt counts the current cycle, so the line is high HOLD_MAX cycles
              if (w_ack_hit) begin
                w_irq_nxt   = 32'd0;
                w_count_nxt = r_count + 32'd1;
                w_state_nxt = ST_IDLE;
              end else if (w_timeout) begin
                w_irq_nxt   = 32'd0;
                w_state_nxt = ST_IDLE;
              end else if (C_HOLD_MAX != 32'd0) begin
                w_hold_cnt_nxt = r_hold_cnt + 32'd1;
              end
            end
            default: begin
              w_irq_nxt   = 32'd0;
              w_state_nxt = ST_IDLE;
            end
          endcase
        end
        default: begin
          w_irq_nxt   = 32'd0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_gap_cnt  <= '0;
      r_id       <= 5'd0;
      r_hold_cnt <= 32'd0;
      r_pc_armed <= 1'b1;
      r_irq      <= 32'd0;
      r_count    <= 32'd0;
      r_mode_q   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_id       <= w_id_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_pc_armed <= w_pc_armed_nxt;
      r_irq      <= w_irq_nxt;
      r_count    <= w_count_nxt;
      r_mode_q   <= mode_i;
    end
  end

  assign irq_o         = r_irq;
  assign irq_pending_o = (r_state == ST_ASSERT);
  assign irq_count_o   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_perturbation_irq_gen.sv
`default_nettype none
// Directed bench for perturbation_irq_gen, built with a 16-cycle hold limit.
module tb_perturbation_irq_gen;

  localparam logic [31:0] SEED     = 32'hACE1_2468;
  localparam int          HOLD     = 16;
  localparam int          MINGAP   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mode, irq_std, irq_mask, pc, pc_trig, seed;
  logic [4:0]  irq_id_cfg, ack_id;
  logic        pc_valid, ack, seed_load;
  logic [31:0] irq;
  logic        pending;
  logic [31:0] count;

  int total = 0;
  int bad   = 0;

  perturbation_irq_gen #(
    .LFSR_SEED (SEED),
    .GAP_W     (8),
    .MIN_GAP   (MINGAP),
    .HOLD_MAX  (HOLD)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mode_i        (mode),
    .irq_std_i     (irq_std),
    .irq_mask_i    (irq_mask),
    .irq_id_cfg_i  (irq_id_cfg),
    .pc_i          (pc),
    .pc_valid_i    (pc_valid),
    .pc_trig_i     (pc_trig),
    .irq_ack_i     (ack),
    .irq_ack_id_i  (ack_id),
    .seed_load_i   (seed_load),
    .seed_i        (seed),
    .irq_o         (irq),
    .irq_pending_o (pending),
    .irq_count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    while (irq == 32'd0 && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, irq != 32'd0}, 32'd1);
  endtask

  function automatic logic [31:0] step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold_len;
    logic [31:0] x, s;
    logic [4:0]  exp_id;

    rst_n = 1'b0; mode = 32'd1; irq_std = 32'hFFFF_FFFF; irq_mask = 32'd0;
    pc = 32'd0; pc_trig = 32'd0; pc_valid = 1'b0; irq_id_cfg = 5'd0;
    ack = 1'b0; ack_id = 5'd0; seed_load = 1'b0; seed = 32'd0;

    // Reset
    repeat (3) tick();
    chk("rst_irq", irq, 32'd0);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_count", count, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // STANDARD pass-through, acks ignored
    irq_std = 32'h0000_0880; tick();
    chk("std_880", irq, 32'h0000_0880);
    irq_std = 32'h8000_0001; tick();
    chk("std_8001", irq, 32'h8000_0001);
    ack = 1'b1; ack_id = 5'd0; tick(); ack = 1'b0;
    chk("std_ack_count", count, 32'd0);
    chk("std_pending", {31'd0, pending}, 32'd0);

    // RANDOM, only line 11 allowed
    irq_mask = 32'h0000_0800; mode = 32'd2;
    seed_load = 1'b1; seed = 32'h5800_0000; tick(); seed_load = 1'b0;
    wait_irq("rnd_wait", n);
    chk("rnd_irq", irq, 32'h0000_0800);
    chk("rnd_gap_min", {31'd0, (n + 1) >= (MINGAP + 3)}, 32'd1);
    chk("rnd_pending", {31'd0, pending}, 32'd1);
    ack = 1'b1; ack_id = 5'd11; tick(); ack = 1'b0;
    chk("rnd_ack_irq", irq, 32'd0);
    chk("rnd_ack_count", count, 32'd1);

    // Wrong-id ack ignored, then mode change mid-ASSERT
    wait_irq("wid_wait", n);
    ack = 1'b1; ack_id = 5'd3; tick(); ack = 1'b0;
    chk("wid_irq", irq, 32'h0000_0800);
    chk("wid_count", count, 32'd1);
    irq_std = 32'h0000_A5A5; mode = 32'd1; tick();
    chk("mchg_irq_zero", irq, 32'd0);
    chk("mchg_pending", {31'd0, pending}, 32'd0);
    tick();
    chk("mchg_passthru", irq, 32'h0000_A5A5);

    // Hold timeout, then ack colliding with timeout
    mode = 32'd2; tick();
    wait_irq("hold_wait", n);
    hold_len = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (irq == 32'd0) break;
      hold_len++;
    end
    chk("hold_len", hold_len, HOLD);
    chk("hold_count", count, 32'd1);
    wait_irq("hold2_wait", n);
    repeat (HOLD - 1) tick();
    chk("hold2_still", irq, 32'h0000_0800);
    ack = 1'b1; ack_id = 5'd11; tick(); ack = 1'b0;
    chk("hold2_irq", irq, 32'd0);
    chk("hold2_count", count, 32'd2);

    // PC_TRIG
    irq_id_cfg = 5'd5; pc_trig = 32'h1C00_0080; mode = 32'd3; tick(); tick();
    pc = 32'h1C00_0084; pc_valid = 1'b1; tick();
    chk("pc_miss", irq, 32'd0);
    pc = 32'h1C00_0080; tick(); pc_valid = 1'b0;
    chk("pc_hit", irq, 32'h0000_0020);
    ack = 1'b1; ack_id = 5'd5; tick(); ack = 1'b0;
    chk("pc_ack_irq", irq, 32'd0);
    chk("pc_ack_count", count, 32'd3);
    pc_valid = 1'b1; tick(); tick(); pc_valid = 1'b0;
    chk("pc_no_retrig", irq, 32'd0);
    pc = 32'h1C00_0100; pc_valid = 1'b1; tick();
    pc = 32'h1C00_0080; tick(); pc_valid = 1'b0;
    chk("pc_retrig", irq, 32'h0000_0020);
    irq_id_cfg = 5'd9; tick();
    chk("pc_id_latched", irq, 32'h0000_0020);
    ack = 1'b1; ack_id = 5'd5; tick(); ack = 1'b0;
    chk("pc_ack2_count", count, 32'd4);

    // Zero seed falls back to LFSR_SEED, then one Galois step
    seed_load = 1'b1; seed = 32'd0; tick(); seed_load = 1'b0;
    chk("seed_zero", dut.r_lfsr, SEED);
    tick();
    chk("lfsr_step", dut.r_lfsr, step(SEED));

    // Exact RANDOM timing from a loaded seed, all lines allowed
    s = 32'h1234_5603;
    irq_mask = 32'hFFFF_FFFF; mode = 32'd2; seed_load = 1'b1; seed = s;
    tick(); seed_load = 1'b0;
    x = s;
    repeat (int'(s[7:0]) + MINGAP + 1) x = step(x);
    exp_id = x[31:27];
    repeat (int'(s[7:0]) + MINGAP + 1) tick();
    chk("exact_pre", irq, 32'd0);
    tick();
    chk("exact_irq", irq, 32'd1 << exp_id);
    ack = 1'b1; ack_id = exp_id; tick(); ack = 1'b0;
    chk("exact_count", count, 32'd5);

    // Async reset mid-ASSERT
    wait_irq("rst_wait", n);
    chk("rst_pre_pending", {31'd0, pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", irq, 32'd0);
    chk("arst_count", count, 32'd0);
    chk("arst_pending", {31'd0, pending}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
